// File: rtl/score_keeper_pkg.sv
// Shared types and helpers for the score keeper: FSM encoding, one-hot decode,
// and the effective player count rule.
package score_keeper_pkg;

    localparam int unsigned NPLAYER_DEF = 4;
    localparam int unsigned SCORE_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitBuzz  = 2'd1,
        StWaitJudge = 2'd2,
        StGameOver  = 2'd3
    } state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for one-hot input; anything else maps to player 1.
    function automatic logic [1:0] onehot_idx4(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // 0 or anything above 4 means a full table of 4 players.
    function automatic logic [2:0] eff_players(input logic [3:0] m);
        return ((m == 4'd0) || (m > 4'd4)) ? 3'd4 : m[2:0];
    endfunction

endpackage

// File: rtl/score_alu.sv
// Saturating add/subtract of a 4-bit operand on one score, computed one bit wider
// so overflow and borrow show up in the extra bit.
module score_alu #(
    parameter int unsigned SCORE_W = 8
) (
    input  logic [SCORE_W-1:0] score,
    input  logic [3:0]         operand,
    input  logic               sub,
    output logic [SCORE_W-1:0] result
);

    logic [SCORE_W:0] wide_a;
    logic [SCORE_W:0] wide_op;
    logic [SCORE_W:0] sum;
    logic [SCORE_W:0] diff;

    assign wide_a  = {1'b0, score};
    assign wide_op = (SCORE_W + 1)'(operand);
    assign sum     = wide_a + wide_op;
    assign diff    = wide_a - wide_op;

    always_comb begin
        if (sub) begin
            result = diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
        end else begin
            result = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Per-player score bank: latches the buzz winner, applies the compere's judgement,
// and publishes scores, leader and the game-over champion.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned NPLAYER    = 4,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned INIT_SCORE = 10,
    parameter int unsigned WIN_SCORE  = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       startgame,
    input  logic [3:0]                 maxuser,
    input  logic [3:0]                 scorejia,
    input  logic [3:0]                 scorejian,
    input  logic                       buzz_valid,
    input  logic [3:0]                 who,
    input  logic                       yes,
    input  logic                       no,
    input  logic                       endtime,
    output logic [NPLAYER*SCORE_W-1:0] scores,
    output logic [3:0]                 leader,
    output logic                       judge_pending,
    output logic                       score_upd,
    output logic                       game_over,
    output logic [3:0]                 champion
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q [NPLAYER];
    logic [SCORE_W-1:0] score_d [NPLAYER];
    logic [3:0]         player_q, player_d;
    logic [2:0]         nact_q, nact_d;
    logic [3:0]         champ_q, champ_d;
    logic               upd_q, upd_d;

    logic [1:0]         sel_idx;
    logic [SCORE_W-1:0] sel_score;
    logic [SCORE_W-1:0] alu_result;
    logic [1:0]         buzz_idx;
    logic               buzz_ok;
    logic               apply_yes;
    logic               apply_no;
    logic               win;

    assign sel_idx   = onehot_idx4(player_q);
    assign sel_score = score_q[sel_idx];
    assign buzz_idx  = onehot_idx4(who);
    assign buzz_ok   = buzz_valid && is_onehot4(who) && ({1'b0, buzz_idx} < nact_q);

    // yes beats endtime; yes with no and without endtime is contradictory and dropped.
    assign apply_yes = yes && (!no || endtime);
    assign apply_no  = !yes && (no || endtime);

    score_alu #(
        .SCORE_W (SCORE_W)
    ) u_alu (
        .score   (sel_score),
        .operand (apply_yes ? scorejia : scorejian),
        .sub     (!apply_yes),
        .result  (alu_result)
    );

    assign win = {1'b0, alu_result} >= (SCORE_W + 1)'(WIN_SCORE);

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        player_d = player_q;
        nact_d   = nact_q;
        champ_d  = champ_q;
        upd_d    = 1'b0;
        if (startgame) begin
            nact_d = eff_players(maxuser);
            for (int i = 0; i < NPLAYER; i++) begin
                score_d[i] = (i < int'(nact_d)) ? SCORE_W'(INIT_SCORE) : '0;
            end
            player_d = '0;
            champ_d  = '0;
            upd_d    = 1'b1;
            state_d  = StWaitBuzz;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWaitBuzz: begin
                    if (buzz_ok) begin
                        player_d = who;
                        state_d  = StWaitJudge;
                    end
                end
                StWaitJudge: begin
                    if (apply_yes || apply_no) begin
                        score_d[sel_idx] = alu_result;
                        upd_d            = (alu_result != sel_score);
                        if (apply_yes && win) begin
                            champ_d = player_q;
                            state_d = StGameOver;
                        end else begin
                            state_d = StWaitBuzz;
                        end
                    end
                end
                StGameOver: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            for (int i = 0; i < NPLAYER; i++) begin
                score_q[i] <= '0;
            end
            player_q <= '0;
            nact_q   <= 3'd4;
            champ_q  <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            player_q <= player_d;
            nact_q   <= nact_d;
            champ_q  <= champ_d;
            upd_q    <= upd_d;
        end
    end

    // Highest active score; strict compare keeps the lowest index on ties.
    always_comb begin
        logic [SCORE_W-1:0] best;
        logic [1:0]         best_idx;
        best     = score_q[0];
        best_idx = 2'd0;
        for (int i = 1; i < NPLAYER; i++) begin
            if ((i < int'(nact_q)) && (score_q[i] > best)) begin
                best     = score_q[i];
                best_idx = 2'(i);
            end
        end
        leader = (state_q == StIdle) ? 4'd0 : (4'd1 << best_idx);
    end

    for (genvar k = 0; k < NPLAYER; k++) begin : g_scores
        assign scores[k*SCORE_W +: SCORE_W] = score_q[k];
    end

    assign judge_pending = (state_q == StWaitJudge);
    assign game_over     = (state_q == StGameOver);
    assign champion      = champ_q;
    assign score_upd     = upd_q;

endmodule
